// File: rtl/aes_selftest_pkg.sv
// Shared types and helpers for the AES known-answer self-test sequencer.
package aes_selftest_pkg;

   localparam int unsigned FAIL_CNT_W = 8;
   localparam int unsigned BLOCK_W    = 128;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENC_LOAD,
      S_ENC_WAIT,
      S_DEC_LOAD,
      S_DEC_WAIT,
      S_NEXT,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      ST_ENC  = 2'd0,
      ST_DEC  = 2'd1,
      ST_BOTH = 2'd2
   } mode_t;

   // Reserved encoding 3 runs both directions.
   function automatic mode_t decode_mode(input logic [1:0] m);
      case (m)
         2'd0:    return ST_ENC;
         2'd1:    return ST_DEC;
         default: return ST_BOTH;
      endcase
   endfunction

   function automatic state_t first_load(input mode_t m);
      return (m == ST_DEC) ? S_DEC_LOAD : S_ENC_LOAD;
   endfunction

   function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
      return (v == '1) ? v : v + FAIL_CNT_W'(1);
   endfunction

endpackage

// File: rtl/aes_st_timer.sv
// Wait-state timer: cleared in LOAD, counts in WAIT, flags the guard cycle and timeout.
module aes_st_timer #(
   parameter  int unsigned TIMEOUT = 64,
   localparam int unsigned CNT_W   = $clog2(TIMEOUT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             guard_c,
   output logic             expired_c
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   assign guard_c   = (count == '0);
   assign expired_c = (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired_c) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/aes_selftest_ctrl.sv
// Built-in self-test sequencer: walks a vector ROM through AES encrypt/decrypt cores and tallies results.
module aes_selftest_ctrl
   import aes_selftest_pkg::*;
#(
   parameter  int unsigned Nk      = 4,
   parameter  int unsigned NUM_VEC = 4,
   parameter  int unsigned TIMEOUT = 64,
   localparam int unsigned KEY_W   = 32 * Nk,
   localparam int unsigned IDX_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [1:0]            mode,
   input  logic                  loop_en,
   output logic [IDX_W-1:0]      vec_idx,
   input  logic [BLOCK_W-1:0]    vec_pt,
   input  logic [BLOCK_W-1:0]    vec_ct,
   input  logic [KEY_W-1:0]      vec_key,
   output logic [KEY_W-1:0]      aes_key,
   output logic [BLOCK_W-1:0]    enc_pt,
   output logic                  enc_load,
   input  logic [BLOCK_W-1:0]    enc_ct,
   input  logic                  enc_valid,
   output logic [BLOCK_W-1:0]    dec_ct,
   output logic                  dec_load,
   input  logic [BLOCK_W-1:0]    dec_pt,
   input  logic                  dec_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [FAIL_CNT_W-1:0] fail_cnt,
   output logic [IDX_W-1:0]      first_fail_idx,
   output logic                  timeout_err,
   output logic [FAIL_CNT_W-1:0] loop_cnt
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
   localparam int unsigned      CNT_W    = $clog2(TIMEOUT);

   state_t state;
   mode_t  mode_q;
   logic   loop_q;

   logic             in_enc_wait, in_dec_wait, in_wait;
   logic             tmr_guard, tmr_expired;
   logic [CNT_W-1:0] tmr_count;
   logic             hit, mismatch, resolve, failed, timed_out;
   state_t           start_first, run_first;

   // Cores see the ROM entry directly; vec_idx only moves in NEXT.
   assign aes_key = vec_key;
   assign enc_pt  = vec_pt;
   assign dec_ct  = vec_ct;

   assign in_enc_wait = (state == S_ENC_WAIT);
   assign in_dec_wait = (state == S_DEC_WAIT);
   assign in_wait     = in_enc_wait || in_dec_wait;

   aes_st_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     ((state == S_ENC_LOAD) || (state == S_DEC_LOAD)),
      .enable    (in_wait),
      .count     (tmr_count),
      .guard_c   (tmr_guard),
      .expired_c (tmr_expired)
   );

   // Valid in the first wait cycle may be stale from a previous operation.
   assign hit       = !tmr_guard && ((in_enc_wait && enc_valid) || (in_dec_wait && dec_valid));
   assign mismatch  = in_enc_wait ? (enc_ct != vec_ct) : (dec_pt != vec_pt);
   assign resolve   = in_wait && (hit || tmr_expired);
   assign failed    = in_wait && (hit ? mismatch : tmr_expired);
   assign timed_out = in_wait && !hit && tmr_expired;

   assign start_first = first_load(decode_mode(mode));
   assign run_first   = first_load(mode_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         mode_q         <= ST_ENC;
         loop_q         <= 1'b0;
         vec_idx        <= '0;
         enc_load       <= 1'b0;
         dec_load       <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail_cnt       <= '0;
         first_fail_idx <= '0;
         timeout_err    <= 1'b0;
         loop_cnt       <= '0;
      end else if (abort) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         enc_load <= 1'b0;
         dec_load <= 1'b0;
      end else begin
         enc_load <= 1'b0;
         dec_load <= 1'b0;

         if (failed) begin
            fail_cnt <= sat_inc(fail_cnt);
            if (fail_cnt == '0) first_fail_idx <= vec_idx;
         end
         if (timed_out) timeout_err <= 1'b1;

         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_q         <= decode_mode(mode);
                  loop_q         <= loop_en;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  fail_cnt       <= '0;
                  first_fail_idx <= '0;
                  timeout_err    <= 1'b0;
                  loop_cnt       <= '0;
                  busy           <= 1'b1;
                  vec_idx        <= '0;
                  state          <= start_first;
                  enc_load       <= (start_first == S_ENC_LOAD);
                  dec_load       <= (start_first == S_DEC_LOAD);
               end
            end
            S_ENC_LOAD: state <= S_ENC_WAIT;
            S_ENC_WAIT: begin
               if (resolve) begin
                  if (mode_q == ST_BOTH) begin
                     state    <= S_DEC_LOAD;
                     dec_load <= 1'b1;
                  end else begin
                     state <= S_NEXT;
                  end
               end
            end
            S_DEC_LOAD: state <= S_DEC_WAIT;
            S_DEC_WAIT: begin
               if (resolve) state <= S_NEXT;
            end
            S_NEXT: begin
               if (vec_idx < LAST_IDX) begin
                  vec_idx  <= vec_idx + IDX_W'(1);
                  state    <= run_first;
                  enc_load <= (run_first == S_ENC_LOAD);
                  dec_load <= (run_first == S_DEC_LOAD);
               end else if (loop_q && (fail_cnt == '0)) begin
                  vec_idx  <= '0;
                  loop_cnt <= sat_inc(loop_cnt);
                  state    <= run_first;
                  enc_load <= (run_first == S_ENC_LOAD);
                  dec_load <= (run_first == S_DEC_LOAD);
               end else begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (fail_cnt == '0);
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_selftest_ctrl.sv
// Self-checking bench: behavioural cores, randomized vector ROM, result model from vector-level rules.
module tb_aes_selftest_ctrl;

   localparam int unsigned NK = 4;
   localparam int unsigned NV = 4;
   localparam int unsigned TO = 16;
   localparam logic [127:0] SCRAM = 128'h5a5a_1234_c3c3_9876_0f0f_abcd_f00d_7777;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [1:0]   mode = 2'd0;
   logic         loop_en = 1'b0;
   logic [1:0]   vec_idx;
   logic [127:0] vec_pt, vec_ct, enc_pt, enc_ct, dec_ct, dec_pt;
   logic [127:0] vec_key, aes_key;
   logic         enc_load, enc_valid = 1'b0, dec_load, dec_valid = 1'b0;
   logic         busy, done, pass, timeout_err;
   logic [7:0]   fail_cnt, loop_cnt;
   logic [1:0]   first_fail_idx;

   logic [127:0] rom_pt [NV];
   logic [127:0] rom_ct [NV];
   logic [127:0] rom_key[NV];

   logic enc_hang = 1'b0, dec_hang = 1'b0;
   int   e_cnt = 0, d_cnt = 0;
   int   n_enc = 0, n_dec = 0;
   int   checks = 0, errors = 0;

   assign vec_pt  = rom_pt[vec_idx];
   assign vec_ct  = rom_ct[vec_idx];
   assign vec_key = rom_key[vec_idx];

   aes_selftest_ctrl #(.Nk(NK), .NUM_VEC(NV), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .loop_en(loop_en),
      .vec_idx(vec_idx), .vec_pt(vec_pt), .vec_ct(vec_ct), .vec_key(vec_key), .aes_key(aes_key),
      .enc_pt(enc_pt), .enc_load(enc_load), .enc_ct(enc_ct), .enc_valid(enc_valid),
      .dec_ct(dec_ct), .dec_load(dec_load), .dec_pt(dec_pt), .dec_valid(dec_valid),
      .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
      .first_fail_idx(first_fail_idx), .timeout_err(timeout_err), .loop_cnt(loop_cnt)
   );

   always #5 clk = ~clk;

   // Stand-in block cipher: invertible, so decrypt of a good ct returns the pt.
   function automatic logic [127:0] f_enc(input logic [127:0] p, input logic [127:0] k);
      return {p[63:0], p[127:64]} ^ k ^ SCRAM;
   endfunction

   function automatic logic [127:0] f_dec(input logic [127:0] c, input logic [127:0] k);
      logic [127:0] x;
      x = c ^ k ^ SCRAM;
      return {x[63:0], x[127:64]};
   endfunction

   // Encrypt core: single valid pulse 1..4 cycles after load, or none when hung.
   always @(posedge clk) begin
      enc_valid <= 1'b0;
      if (enc_load) begin
         e_cnt  <= int'($urandom_range(1, 4));
         enc_ct <= f_enc(enc_pt, aes_key);
      end else if (e_cnt > 0) begin
         e_cnt <= e_cnt - 1;
         if (e_cnt == 1 && !enc_hang) enc_valid <= 1'b1;
      end
   end

   always @(posedge clk) begin
      dec_valid <= 1'b0;
      if (dec_load) begin
         d_cnt  <= int'($urandom_range(1, 4));
         dec_pt <= f_dec(dec_ct, aes_key);
      end else if (d_cnt > 0) begin
         d_cnt <= d_cnt - 1;
         if (d_cnt == 1 && !dec_hang) dec_valid <= 1'b1;
      end
   end

   always @(posedge clk) begin
      if (enc_load) n_enc <= n_enc + 1;
      if (dec_load) n_dec <= n_dec + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fill_rom(input logic [NV-1:0] corrupt, input bit fips);
      for (int i = 0; i < int'(NV); i++) begin
         rom_pt[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
         rom_key[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
         if (fips && i == 0) begin
            rom_pt[i]  = 128'h00112233445566778899aabbccddeeff;
            rom_key[i] = 128'h000102030405060708090a0b0c0d0e0f;
         end
         rom_ct[i] = f_enc(rom_pt[i], rom_key[i]);
         if (corrupt[i]) rom_ct[i][0] = ~rom_ct[i][0];
      end
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_done_reached"}, 32'(done), 32'd1);
   endtask

   task automatic pulse_start(input logic [1:0] m, input logic lp);
      mode    = m;
      loop_en = lp;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   // One run; expectations derived per vector from mode, ROM corruption and core hangs.
   task automatic run(input string tag, input logic [1:0] m, input logic lp,
                      input logic [NV-1:0] corrupt, input logic eh, input logic dh,
                      input bit poke, input bit fips);
      bit has_enc, has_dec;
      int exp_fails, exp_first, e0, d0;
      bit exp_to;
      has_enc   = (m != 2'd1);
      has_dec   = (m != 2'd0);
      exp_fails = 0;
      exp_first = 0;
      exp_to    = 1'b0;
      for (int i = 0; i < int'(NV); i++) begin
         if (has_enc && (eh || corrupt[i])) begin
            if (exp_fails == 0) exp_first = i;
            exp_fails++;
            if (eh) exp_to = 1'b1;
         end
         if (has_dec && (dh || corrupt[i])) begin
            if (exp_fails == 0) exp_first = i;
            exp_fails++;
            if (dh) exp_to = 1'b1;
         end
      end
      fill_rom(corrupt, fips);
      enc_hang = eh;
      dec_hang = dh;
      e0 = n_enc;
      d0 = n_dec;
      pulse_start(m, lp);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done_clr"}, 32'(done), 32'd0);
      if (poke) begin
         repeat (9) @(negedge clk);
         pulse_start((m == 2'd1) ? 2'd0 : 2'd1, ~lp);
      end
      wait_done(tag);
      chk({tag, "_pass"}, 32'(pass), 32'(exp_fails == 0));
      chk({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(exp_fails));
      chk({tag, "_first_idx"}, 32'(first_fail_idx), 32'(exp_first));
      chk({tag, "_timeout"}, 32'(timeout_err), 32'(exp_to));
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      chk({tag, "_loop_cnt"}, 32'(loop_cnt), 32'd0);
      @(negedge clk);
      chk({tag, "_enc_loads"}, 32'(n_enc - e0), has_enc ? 32'(NV) : 32'd0);
      chk({tag, "_dec_loads"}, 32'(n_dec - d0), has_dec ? 32'(NV) : 32'd0);
      repeat (2) @(negedge clk);
      chk({tag, "_done_hold"}, 32'(done), 32'd1);
   endtask

   initial begin
      int n;
      fill_rom('0, 1'b1);
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          {6'd0, busy, done, pass, timeout_err, enc_load, dec_load, fail_cnt, loop_cnt, vec_idx, first_fail_idx},
          32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_after_reset", {30'd0, busy, done}, 32'd0);

      run("fips_both", 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
      run("enc_bad2",  2'd0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
      run("dec_hang",  2'd1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
      run("mode3",     2'd3, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
      run("enc_hang3", 2'd3, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
      run("mid_start", 2'd2, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0);
      run("loop_fail", 2'd0, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int r = 0; r < 4; r++) begin
         logic [1:0] rm;
         logic [3:0] rc;
         rm = 2'($urandom_range(0, 3));
         rc = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom());
         run("rand", rm, 1'b0, rc, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Loop until three full passes, then abort.
      fill_rom('0, 1'b0);
      pulse_start(2'd2, 1'b1);
      n = 0;
      while (loop_cnt != 8'd3 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("loop_reached_3", 32'(loop_cnt), 32'd3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_loads", {30'd0, enc_load, dec_load}, 32'd0);
      chk("abort_loop_cnt", 32'(loop_cnt), 32'd3);
      chk("abort_fail_cnt", 32'(fail_cnt), 32'd0);
      repeat (5) @(negedge clk);
      chk("abort_stays_idle", {30'd0, busy, done}, 32'd0);

      // Asynchronous reset while waiting on the encrypt core, after one failure.
      fill_rom(4'b0010, 1'b0);
      pulse_start(2'd0, 1'b0);
      n = 0;
      while (!(enc_load && vec_idx == 2'd2) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("pre_reset_load", 32'(enc_load), 32'd1);
      @(negedge clk);
      chk("pre_reset_fail_cnt", 32'(fail_cnt), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset_outputs",
          {6'd0, busy, done, pass, timeout_err, enc_load, dec_load, fail_cnt, loop_cnt, vec_idx, first_fail_idx},
          32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run("post_reset", 2'd2, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
